// File: rtl/ram_write_control_pkg.sv
// Frame geometry and FSM encoding shared by the raster RAM writer and the ROM
// raster read controller.
package ram_write_control_pkg;

  localparam int unsigned RWC_IMG_W  = 250;
  localparam int unsigned RWC_IMG_H  = 114;
  localparam int unsigned RWC_PIXELS = RWC_IMG_W * RWC_IMG_H;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_e;

endpackage

// File: rtl/ram_write_control_pos.sv
// Column/row tracker holding the raster position of the next pixel to write.
module ram_write_control_pos
  import ram_write_control_pkg::*;
#(
  parameter int unsigned IMG_W = RWC_IMG_W,
  parameter int unsigned IMG_H = RWC_IMG_H,
  parameter int unsigned COL_W = 8,
  parameter int unsigned ROW_W = 7
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             from_origin_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             last_o
);

  logic [COL_W-1:0] col_q, col_d, col_base;
  logic [ROW_W-1:0] row_q, row_d, row_base;

  // from_origin_i advances from (0,0) rather than the held position, so an
  // SOF pixel leaves the counter pointing at the second pixel of the frame.
  always_comb begin
    col_base = from_origin_i ? '0 : col_q;
    row_base = from_origin_i ? '0 : row_q;
    col_d    = col_q;
    row_d    = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (inc_i) begin
      if (col_base == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = row_base + ROW_W'(1);
      end else begin
        col_d = col_base + COL_W'(1);
        row_d = row_base;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = (col_q == COL_W'(IMG_W - 1)) && (row_q == ROW_W'(IMG_H - 1));

endmodule

// File: rtl/ram_write_control.sv
// Raster frame-buffer writer: stores one pixel per valid cycle at sequential
// RAM addresses, tracks column/row, flags frame completion and SOF resync.
module ram_write_control
  import ram_write_control_pkg::*;
#(
  parameter int unsigned IMG_W  = RWC_IMG_W,
  parameter int unsigned IMG_H  = RWC_IMG_H,
  parameter int unsigned ADDR_W = $clog2(RWC_PIXELS),
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COL_W  = $clog2(RWC_IMG_W),
  parameter int unsigned ROW_W  = $clog2(RWC_IMG_H)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [DATA_W-1:0] pix_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [COL_W-1:0]  wr_column,
  output logic [ROW_W-1:0]  wr_row,
  output logic              frame_done,
  output logic              sync_err,
  output logic [7:0]        frame_cnt
);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic              done_q;
  logic              err_q;
  logic [7:0]        fcnt_q;

  logic              accept;
  logic              last_pix;
  logic              resync;
  logic              drop;
  logic [ADDR_W-1:0] cur_addr;
  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic [COL_W-1:0]  pos_col;
  logic [ROW_W-1:0]  pos_row;
  logic              pos_last;

  ram_write_control_pos #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_pos (
    .clk           (clk),
    .rstn          (rstn),
    .clr_i         (last_pix),
    .inc_i         (accept && !last_pix),
    .from_origin_i (pix_sof),
    .col_o         (pos_col),
    .row_o         (pos_row),
    .last_o        (pos_last)
  );

  always_comb begin
    accept   = pix_valid && (pix_sof || (state_q == ST_WRITE));
    last_pix = pix_valid && !pix_sof && (state_q == ST_WRITE) && pos_last;
    resync   = pix_valid && pix_sof && (state_q == ST_WRITE);
    drop     = pix_valid && !pix_sof && (state_q == ST_IDLE);

    cur_addr = pix_sof ? '0 : addr_q;
    cur_col  = pix_sof ? '0 : pos_col;
    cur_row  = pix_sof ? '0 : pos_row;

    addr_d = addr_q;
    if (last_pix) begin
      addr_d = '0;
    end else if (accept) begin
      addr_d = cur_addr + ADDR_W'(1);
    end

    state_d = state_q;
    if (last_pix) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      state_d = ST_WRITE;
    end
  end

  // Position/data outputs hold their last write between accepted pixels.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_en_q <= accept;
      done_q  <= last_pix;
      err_q   <= resync || drop;
      if (accept) begin
        wr_addr_q <= cur_addr;
        wdata_q   <= pix_data;
        col_q     <= cur_col;
        row_q     <= cur_row;
      end
      if (last_pix) begin
        fcnt_q <= fcnt_q + 8'd1;
      end
    end
  end

  assign ram_wr_en  = wr_en_q;
  assign ram_addr   = wr_addr_q;
  assign ram_wdata  = wdata_q;
  assign wr_column  = col_q;
  assign wr_row     = row_q;
  assign frame_done = done_q;
  assign sync_err   = err_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: doc/ram_write_control.md
# ram_write_control

Frame-buffer writer for the image pipeline. Takes the processed raster pixel stream, one pixel per valid cycle, and writes it into the result RAM at sequential addresses. It tracks the column and row of each write, signals frame completion, and resynchronises on start-of-frame markers. It is the write-side counterpart of the ROM raster read controller: same frame geometry, opposite direction.

## Interface
Parameters:
- IMG_W, 250: pixels per row.
- IMG_H, 114: rows per frame.
- ADDR_W, 15: RAM address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H.
- DATA_W, 8: pixel width.
- COL_W, 8: column counter width.
- ROW_W, 7: row counter width.

Ports:
- clk, in, 1: clock.
- rstn, in, 1: reset, asynchronous, active-low.
- pix_valid, in, 1: pixel present this cycle.
- pix_sof, in, 1: marks the first pixel of a frame; qualified by pix_valid.
- pix_data, in, DATA_W: pixel value.
- ram_wr_en, out, 1: RAM write strobe.
- ram_addr, out, ADDR_W: RAM write address.
- ram_wdata, out, DATA_W: RAM write data.
- wr_column, out, COL_W: column of the current write.
- wr_row, out, ROW_W: row of the current write.
- frame_done, out, 1: one-cycle pulse coincident with the last write of a frame.
- sync_err, out, 1: one-cycle pulse on a dropped or resynchronising pixel.
- frame_cnt, out, 8: completed-frame count; wraps 255→0.

## Operation
- Two-state FSM: IDLE, WRITE. Reset state is IDLE.
- IDLE:
  - pix_valid && pix_sof: write the pixel to address 0 (column 0, row 0), then go to WRITE.
  - pix_valid && !pix_sof: drop the pixel and pulse sync_err.
- WRITE, on pix_valid && !pix_sof:
  - Write at the next address; address increments by 1.
  - Column increments; at IMG_W-1 it wraps to 0 and row increments.
- Last pixel (address IMG_W*IMG_H-1, column IMG_W-1, row IMG_H-1):
  - Write it and pulse frame_done.
  - Increment frame_cnt.
  - Return to IDLE with address, column and row cleared.
- WRITE, on pix_valid && pix_sof (early SOF):
  - Pulse sync_err.
  - Write the pixel at address 0, column 0, row 0.
  - Stay in WRITE; the frame restarts. No frame_done and no frame_cnt change.
- pix_valid low: no write. Counters and state hold, so gaps of any length are allowed.
- Addressing: address comes from a running counter with no multiply. The counter never exceeds IMG_W*IMG_H-1.
- Input data is not transformed.

## Timing
- All outputs are registered.
- Input sampled at edge N appears at edge N+1: ram_wr_en=1 with ram_addr, ram_wdata, wr_column and wr_row for that pixel.
- ram_wr_en is high for exactly one cycle per accepted pixel.
- frame_done and sync_err are single-cycle pulses aligned with the corresponding write (or, for a dropped pixel, with the cycle after the drop).
- Back-to-back frames: a pix_sof arriving the cycle after the last pixel is accepted with no bubble.
- Reset values: every output is 0 and state is IDLE.
- Reset asserted mid-frame: the partial frame is abandoned and frame_cnt clears. After release, a pix_sof is required to start.
- No backpressure: the block always accepts input.

## Structure
- Shared package holds the frame-geometry constants (IMG_W, IMG_H, the pixel count IMG_W*IMG_H) and the FSM state encoding. The ROM read controller uses the same constants.
- Single flat module; no sub-module needed. Optional pos_counter sub-module for the column/row pair, if it is shared with the read side.

## Test plan
- Full frame, 28500 continuous valid pixels with pix_sof on the first:
  - Addresses run 0..28499.
  - Last write shows column 249, row 113.
  - frame_done pulses once, on the 28500th write; frame_cnt=1.
- Two back-to-back frames with no gap:
  - Second SOF pixel writes address 0 one cycle after the first frame's last write.
  - frame_cnt=2.
  - No sync_err.
- Five valid pixels without pix_sof after reset:
  - No ram_wr_en.
  - Five sync_err pulses.
  - State stays IDLE.
- pix_sof at pixel 1000 of a frame:
  - sync_err pulses; the write goes to address 0.
  - The frame then completes 28500 pixels later with a single frame_done.
- Random pix_valid gaps (about 50% duty) over a full frame:
  - Write sequence is identical to the continuous case.
  - No writes occur during gaps.
- rstn pulsed at pixel 500, then a new SOF frame:
  - Outputs go to 0 immediately on reset.
  - The new frame writes from address 0.
  - frame_cnt ends at 1.
